// File: rtl/k2_io_pkg.sv
// Shared types for the K2 front-panel input conditioning blocks.
package k2_io_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_t;

  localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; 2-cycle latency, no backpressure.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/btn_step_debouncer.sv
// Step button conditioner: sync, debounce both edges, one-cycle strobe per press plus auto-repeat.
// Strobe/level rise DEBOUNCE_CYCLES+3 edges after first high sample; no backpressure.
module btn_step_debouncer
  import k2_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int REPEAT_EN            = 1,
  parameter int REPEAT_DELAY_CYCLES  = 50000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_in,
  output logic                   step_pulse,
  output logic                   btn_level,
  output logic [PRESS_CNT_W-1:0] press_count
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD_CYCLES - 1);

  logic                   s2;
  btn_state_t             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [RPT_W-1:0]       rpt_q;
  logic                   first_rpt_q;
  logic                   step_pulse_q;
  logic                   btn_level_q;
  logic [PRESS_CNT_W-1:0] press_count_q;
  logic [RPT_W-1:0]       rpt_term;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (btn_in),
    .q_o   (s2)
  );

  // The first repeat waits the long delay, later ones use the shorter period.
  assign rpt_term = first_rpt_q ? RPT_FIRST : RPT_PERIOD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rpt_q         <= '0;
      first_rpt_q   <= 1'b0;
      step_pulse_q  <= 1'b0;
      btn_level_q   <= 1'b0;
      press_count_q <= '0;
    end else begin
      step_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s2) begin
            state_q <= PRESS_CHK;
            cnt_q   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s2) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= HELD;
            btn_level_q   <= 1'b1;
            step_pulse_q  <= 1'b1;
            press_count_q <= press_count_q + 1'b1;
            rpt_q         <= '0;
            first_rpt_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          // Release wins over a repeat that would fire on the same edge.
          if (!s2) begin
            state_q <= REL_CHK;
            cnt_q   <= '0;
          end else if (REPEAT_EN != 0) begin
            if (rpt_q == rpt_term) begin
              step_pulse_q  <= 1'b1;
              press_count_q <= press_count_q + 1'b1;
              rpt_q         <= '0;
              first_rpt_q   <= 1'b0;
            end else begin
              rpt_q <= rpt_q + 1'b1;
            end
          end
        end
        REL_CHK: begin
          // Bounce back to HELD keeps rpt_q/first_rpt_q so repeat timing resumes.
          if (s2) begin
            state_q <= HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            btn_level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign step_pulse  = step_pulse_q;
  assign btn_level   = btn_level_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_btn_step_debouncer.sv
// Directed bench for btn_step_debouncer with short debounce/repeat timings.
module tb_btn_step_debouncer;
  import k2_io_pkg::*;

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic       step_pulse_a, btn_level_a;
  logic       step_pulse_b, btn_level_b;
  logic [7:0] press_count_a, press_count_b;

  logic [63:0] pulse_a, pulse_b, level_a;
  int n_cmp;
  int n_err;

  btn_step_debouncer #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(3)
  ) dut_a (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .step_pulse(step_pulse_a), .btn_level(btn_level_a), .press_count(press_count_a)
  );

  btn_step_debouncer #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(3)
  ) dut_b (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .step_pulse(step_pulse_b), .btn_level(btn_level_b), .press_count(press_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    btn_in = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Bit e of pat is the button value sampled at edge e; outputs recorded after that edge.
  task automatic run_trace(input logic [63:0] pat, input int n);
    pulse_a = '0;
    pulse_b = '0;
    level_a = '0;
    for (int e = 1; e <= n; e++) begin
      btn_in = pat[e];
      @(posedge clk);
      #1;
      pulse_a[e] = step_pulse_a;
      pulse_b[e] = step_pulse_b;
      level_a[e] = btn_level_a;
    end
    btn_in = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    btn_in = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_pulse", 64'(step_pulse_a), 64'd0);
    chk_eq("rst_level", 64'(btn_level_a), 64'd0);
    chk_eq("rst_count", 64'(press_count_a), 64'd0);
    chk_eq("rst_state", 64'(dut_a.state_q), 64'(IDLE));
    reset = 1'b0;

    // Clean press: high for edges 1..8.
    do_reset();
    run_trace(64'h1FE, 20);
    chk_eq("clean_pulse", pulse_a, 64'h80);
    chk_eq("clean_level", level_a, 64'h7F80);
    chk_eq("clean_count", 64'(press_count_a), 64'd1);

    // Bounce on press: 1,1,0,1,1,1,0.
    do_reset();
    run_trace(64'h76, 14);
    chk_eq("bounce_pulse", pulse_a, 64'h0);
    chk_eq("bounce_level", level_a, 64'h0);
    chk_eq("bounce_count", 64'(press_count_a), 64'd0);
    chk_eq("bounce_state", 64'(dut_a.state_q), 64'(IDLE));

    // Release bounce: high 1..8, low 9..10, high 11, low after.
    do_reset();
    run_trace(64'h9FE, 24);
    chk_eq("relb_pulse", pulse_a, 64'h80);
    chk_eq("relb_level", level_a, 64'h3FF80);
    chk_eq("relb_count", 64'(press_count_a), 64'd1);

    // Auto-repeat: high for edges 1..29.
    do_reset();
    run_trace(64'h3FFF_FFFE, 40);
    chk_eq("rpt_pulse", pulse_a, 64'h2492_0080);
    chk_eq("rpt_level", level_a, 64'hF_FFFF_FF80);
    chk_eq("rpt_count", 64'(press_count_a), 64'd6);
    chk_eq("norpt_pulse", pulse_b, 64'h80);
    chk_eq("norpt_count", 64'(press_count_b), 64'd1);

    // Counter wrap over 256 short presses.
    do_reset();
    for (int p = 0; p < 255; p++) run_trace(64'h7E, 14);
    chk_eq("wrap_255", 64'(press_count_a), 64'd255);
    run_trace(64'h7E, 14);
    chk_eq("wrap_0", 64'(press_count_a), 64'd0);
    chk_eq("wrap_0_b", 64'(press_count_b), 64'd0);
    run_trace(64'h7E, 14);
    chk_eq("wrap_1", 64'(press_count_a), 64'd1);

    // Reset during PRESS_CHK.
    run_trace(64'h1E, 4);
    chk_eq("mid_state", 64'(dut_a.state_q), 64'(PRESS_CHK));
    btn_in = 1'b1;
    reset  = 1'b1;
    #1;
    chk_eq("mid_rst_pulse", 64'(step_pulse_a), 64'd0);
    chk_eq("mid_rst_level", 64'(btn_level_a), 64'd0);
    chk_eq("mid_rst_count", 64'(press_count_a), 64'd0);
    @(posedge clk);
    #1;
    chk_eq("mid_rst_hold", 64'(step_pulse_a), 64'd0);
    btn_in = 1'b0;
    reset  = 1'b0;
    @(posedge clk);
    #1;
    run_trace(64'h7E, 14);
    chk_eq("post_rst_pulse", pulse_a, 64'h80);
    chk_eq("post_rst_count", 64'(press_count_a), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
